rice_bus_memory_responder: RTL and testbench
============================================

Name: rice_bus_memory_responder

Overview:
Responder (slave) end of the rice bus protocol. It serves instruction fetch and data accesses issued by the core from a word-organised memory. Accepted requests return responses in order, after a configurable latency, with a bounded number outstanding. It is used as the memory model behind the core's instruction and data buses in the core-level bench and in FPGA bring-up.

Parameters:
ADDRESS_WIDTH, 32, width of the request address.
DATA_WIDTH, 32, width of the data bus; strobe width is DATA_WIDTH/8.
WORDS, 1024, memory depth in words; must be a power of 2.
BASE_ADDRESS, 32'h0000_0000, byte address of word 0.
LATENCY, 2, cycles from request acceptance to response availability; must be 1 or more.
OUTSTANDING, 4, maximum number of accepted requests whose response has not yet been consumed; must be 1 or more.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_request_valid  input  1  request present
o_request_ready  output  1  request can be accepted
i_address  input  ADDRESS_WIDTH  byte address
i_write  input  1  1 = write, 0 = read
i_write_data  input  DATA_WIDTH  write data
i_strobe  input  DATA_WIDTH/8  byte enables for writes
o_response_valid  output  1  response present
i_response_ready  input  1  response consumed
o_read_data  output  DATA_WIDTH  read data; 0 for writes and errors
o_error  output  1  access error

Behaviour:
- Reset: single clock i_clk; reset is synchronous and active-low (i_rst_n).
  - On reset, o_response_valid=0, o_error=0, o_read_data=0 and o_request_ready=1 in the following cycle.
  - All in-flight and queued responses are discarded, including when reset arrives mid-operation.
  - Memory contents are not reset.
- Acceptance: a request is accepted when i_request_valid && o_request_ready at a rising edge.
- Address decode: offset = i_address - BASE_ADDRESS, computed modulo 2^ADDRESS_WIDTH.
  - error = (offset >= WORDS*DATA_WIDTH/8) || (offset low log2(DATA_WIDTH/8) bits != 0).
  - word index = offset >> log2(DATA_WIDTH/8).
- Writes: when accepted and error=0, the write updates the bytes enabled by i_strobe in that same edge. Bytes with a strobe of 0 are unchanged. Errored writes do not modify memory.
- Reads: data is sampled from memory at acceptance, so a read sees every write accepted before it.
- Latency pipeline: an accepted request enters a LATENCY-stage shift pipeline carrying {error, read_data}.
  - The pipeline advances every cycle with no stall.
  - Stage LATENCY pushes into a response FIFO of depth OUTSTANDING.
- Response output: o_response_valid = FIFO not empty; the FIFO head drives o_read_data and o_error.
  - Pop on o_response_valid && i_response_ready.
  - The earliest response is visible LATENCY cycles after the acceptance edge, e.g. accepted at edge N, valid after edge N+LATENCY.
- Credit counter: count = pipeline occupancy + FIFO occupancy, range 0..OUTSTANDING.
  - Increments on accept and decrements on pop. An accept and a pop in the same cycle leave it unchanged.
  - o_request_ready = (count < OUTSTANDING), registered-free combinational from count.
  - A pop in the current cycle does not raise ready in that cycle, so there is no ready-on-pop combinational path.
- Full: count == OUTSTANDING, so ready=0.
  - Because the counter reserves FIFO space, the pipeline can never push into a full FIFO.
- FIFO: simultaneous push and pop when the FIFO is full or empty are legal.
  - Push and pop pointers wrap modulo OUTSTANDING. A non-power-of-2 OUTSTANDING is supported with explicit wrap.
- Ordering: responses are returned strictly in acceptance order, whether read, write or error.
- Back-to-back: one accept per cycle is sustainable when i_response_ready=1 and OUTSTANDING >= LATENCY+1.

Decomposition:
- rice_bus_pkg: rice_bus_response struct {error, read_data}.
- rice_bus_pkg: the constant function for strobe width.
- rice_bus_pkg: byte-lane merge function (data, new_data, strobe).
- One sub-module, rice_bus_response_fifo: parameterised depth and type, with push, pop, empty and full flags. It holds the response queue.
- Decode, memory, pipeline and credit counter stay in the top module.

Test Plan:
- Reset then write 32'hDEAD_BEEF with strobe 4'hF to 0x10, then read 0x10 -> two responses, LATENCY=2 cycles after each accept; write returns read_data=0, error=0; read returns 32'hDEAD_BEEF.
- Write 32'h1122_3344 to 0x20, then write 32'hAABB_CCDD with strobe 4'b0101, then read 0x20 -> read returns 32'h11BB_33DD.
- Read address 0x1002 (misaligned) and 0x1000 (out of range, WORDS=1024) -> both o_error=1, o_read_data=0; memory unchanged.
- Hold i_response_ready=0 and issue 6 back-to-back reads -> o_request_ready drops after 4 accepts; release ready -> the remaining 2 are accepted, and all 6 return in order with the correct data.
- Continuous valid and ready with LATENCY=2 and OUTSTANDING=4 -> one accept and one response per cycle in steady state, with no ready bubbles.
- Assert i_rst_n=0 for one cycle with 3 responses outstanding -> next cycle o_response_valid=0 and o_request_ready=1; memory data written before the reset is still readable.

Source files
------------

// File: rtl/rice_bus_pkg.sv
// Shared types and helpers for the rice bus: response payload, strobe sizing and byte-lane merge.
package rice_bus_pkg;

  localparam int RICE_BUS_DATA_WIDTH = 32;

  function automatic int strobe_width(input int data_width);
    return data_width / 8;
  endfunction

  localparam int RICE_BUS_STROBE_WIDTH = strobe_width(RICE_BUS_DATA_WIDTH);

  typedef logic [RICE_BUS_DATA_WIDTH-1:0] rice_bus_word_t;

  typedef struct packed {
    logic           error;
    rice_bus_word_t read_data;
  } rice_bus_response_t;

  // Lanes with a clear strobe keep the old byte.
  function automatic rice_bus_word_t merge_bytes(
    input rice_bus_word_t                   data,
    input rice_bus_word_t                   new_data,
    input logic [RICE_BUS_STROBE_WIDTH-1:0] strobe
  );
    rice_bus_word_t merged;
    merged = data;
    for (int b = 0; b < RICE_BUS_STROBE_WIDTH; b++) begin
      if (strobe[b]) begin
        merged[8*b +: 8] = new_data[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/rice_bus_response_fifo.sv
// Response queue for the rice bus responder; pointers wrap explicitly so any depth works.
module rice_bus_response_fifo
  import rice_bus_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = rice_bus_response_t
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic empty,
  output logic full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // A pop frees the head slot, so a push into a full queue is fine in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = storage[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rice_bus_memory_responder.sv
// Rice bus responder: word memory with fixed-latency, in-order responses and credit-limited acceptance.
module rice_bus_memory_responder
  import rice_bus_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = RICE_BUS_DATA_WIDTH,
  parameter int                       WORDS         = 1024,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0,
  parameter int                       LATENCY       = 2,
  parameter int                       OUTSTANDING   = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_request_valid,
  output logic                               o_request_ready,
  input  logic [ADDRESS_WIDTH-1:0]           i_address,
  input  logic                               i_write,
  input  logic [DATA_WIDTH-1:0]              i_write_data,
  input  logic [strobe_width(DATA_WIDTH)-1:0] i_strobe,
  output logic                               o_response_valid,
  input  logic                               i_response_ready,
  output logic [DATA_WIDTH-1:0]              o_read_data,
  output logic                               o_error
);

  localparam int BYTE_BITS  = $clog2(strobe_width(DATA_WIDTH));
  localparam int INDEX_BITS = $clog2(WORDS);
  localparam int COUNT_W    = $clog2(OUTSTANDING + 1);

  logic [ADDRESS_WIDTH-1:0] offset;
  logic                     misaligned;
  logic                     out_of_range;
  logic                     addr_error;
  logic [INDEX_BITS-1:0]    word_index;
  logic                     accept;
  logic                     pop;
  logic [COUNT_W-1:0]       count;
  logic [DATA_WIDTH-1:0]    mem [WORDS];
  rice_bus_response_t       accept_response;
  logic [LATENCY-1:0]       stage_valid;
  rice_bus_response_t       stage_data [LATENCY];
  rice_bus_response_t       fifo_head;
  logic                     fifo_empty;
  logic                     fifo_full_unused;

  // WORDS is a power of two, so any offset bit above the word index means out of range.
  assign offset       = i_address - BASE_ADDRESS;
  assign misaligned   = |offset[BYTE_BITS-1:0];
  assign out_of_range = |(offset >> (BYTE_BITS + INDEX_BITS));
  assign addr_error   = misaligned || out_of_range;
  assign word_index   = offset[BYTE_BITS +: INDEX_BITS];

  assign o_request_ready = (count < COUNT_W'(OUTSTANDING));
  assign accept          = i_request_valid && o_request_ready;
  assign pop             = o_response_valid && i_response_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst_n && accept && i_write && !addr_error) begin
      mem[word_index] <= merge_bytes(mem[word_index], i_write_data, i_strobe);
    end
  end

  assign accept_response.error     = addr_error;
  assign accept_response.read_data = (addr_error || i_write) ? '0 : mem[word_index];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stage_valid <= '0;
    end else begin
      stage_valid[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    stage_data[0] <= accept_response;
    for (int i = 1; i < LATENCY; i++) begin
      stage_data[i] <= stage_data[i-1];
    end
  end

  // Counting pipeline plus queue occupancy reserves queue space before a request is taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  rice_bus_response_fifo #(
    .DEPTH (OUTSTANDING),
    .T     (rice_bus_response_t)
  ) u_response_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (stage_valid[LATENCY-1]),
    .push_data (stage_data[LATENCY-1]),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full_unused)
  );

  assign o_response_valid = !fifo_empty;
  assign o_read_data      = fifo_empty ? '0 : fifo_head.read_data;
  assign o_error          = !fifo_empty && fifo_head.error;

endmodule

// File: tb/tb_rice_bus_memory_responder.sv
// Bench for the rice bus responder: directed scenarios plus random traffic against a word-array model.
module tb_rice_bus_memory_responder;

  localparam int          ADDRESS_WIDTH = 32;
  localparam int          DATA_WIDTH    = 32;
  localparam int          WORDS         = 1024;
  localparam logic [31:0] BASE_ADDRESS  = 32'h0000_0000;
  localparam int          LATENCY       = 2;
  localparam int          OUTSTANDING   = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_request_valid;
  logic        o_request_ready;
  logic [31:0] i_address;
  logic        i_write;
  logic [31:0] i_write_data;
  logic [3:0]  i_strobe;
  logic        o_response_valid;
  logic        i_response_ready;
  logic [31:0] o_read_data;
  logic        o_error;

  rice_bus_memory_responder #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .WORDS         (WORDS),
    .BASE_ADDRESS  (BASE_ADDRESS),
    .LATENCY       (LATENCY),
    .OUTSTANDING   (OUTSTANDING)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_request_valid  (i_request_valid),
    .o_request_ready  (o_request_ready),
    .i_address        (i_address),
    .i_write          (i_write),
    .i_write_data     (i_write_data),
    .i_strobe         (i_strobe),
    .o_response_valid (o_response_valid),
    .i_response_ready (i_response_ready),
    .o_read_data      (o_read_data),
    .o_error          (o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
    logic [3:0]  strobe;
  } req_t;

  typedef struct {
    logic        error;
    logic [31:0] data;
    int          due;
  } resp_t;

  req_t        pending_q[$];
  resp_t       expected_q[$];
  logic [31:0] model_mem [WORDS];
  int          cycle = 0;
  int          tests = 0;
  int          failures = 0;
  int          accept_total = 0;
  int          pop_total = 0;
  int          bubble_count = 0;
  logic        response_ready_drive = 1'b1;
  logic        random_ready = 1'b0;

  function automatic req_t makeRequest(input logic [31:0] addr, input logic write,
                                       input logic [31:0] data, input logic [3:0] strobe);
    req_t r;
    r.addr   = addr;
    r.write  = write;
    r.data   = data;
    r.strobe = strobe;
    return r;
  endfunction

  // Reference: byte-addressed view of a word array, responses due LATENCY edges after the accept edge.
  function automatic resp_t modelAccess(input req_t r);
    resp_t       e;
    logic [31:0] offset;
    offset  = r.addr - BASE_ADDRESS;
    e.error = (offset >= 32'(WORDS * 4)) || (offset % 4 != 0);
    e.data  = '0;
    e.due   = cycle + 1 + LATENCY;
    if (!e.error) begin
      if (r.write) begin
        for (int b = 0; b < 4; b++) begin
          if (r.strobe[b]) model_mem[offset / 4][8*b +: 8] = r.data[8*b +: 8];
        end
      end else begin
        e.data = model_mem[offset / 4];
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Called at a falling edge: drive, check outputs against the model, then advance one cycle.
  task automatic applyStimulus(input req_t r, input logic present, output logic accepted);
    logic exp_valid;
    i_request_valid  = present;
    i_address        = r.addr;
    i_write          = r.write;
    i_write_data     = r.data;
    i_strobe         = r.strobe;
    i_response_ready = response_ready_drive;
    #1;
    exp_valid = 1'b0;
    if (expected_q.size() > 0) exp_valid = (expected_q[0].due <= cycle);
    checkOutput("request_ready", o_request_ready, expected_q.size() < OUTSTANDING);
    checkOutput("response_valid", o_response_valid, exp_valid);
    if (exp_valid) begin
      checkOutput("read_data", o_read_data, expected_q[0].data);
      checkOutput("error", o_error, expected_q[0].error);
    end
    accepted = present && o_request_ready;
    if (present && !accepted) bubble_count++;
    if (exp_valid && response_ready_drive) begin
      pop_total++;
      void'(expected_q.pop_front());
    end
    if (accepted) begin
      accept_total++;
      expected_q.push_back(modelAccess(r));
    end
    @(posedge i_clk);
    cycle++;
    @(negedge i_clk);
  endtask

  task automatic stepCycle();
    logic acc;
    if (random_ready) response_ready_drive = ($urandom_range(0, 3) != 0);
    if (pending_q.size() > 0) begin
      applyStimulus(pending_q[0], 1'b1, acc);
      if (acc) void'(pending_q.pop_front());
    end else begin
      applyStimulus(makeRequest('0, 1'b0, '0, '0), 1'b0, acc);
    end
  endtask

  task automatic runUntilIdle(input string tag, input int budget);
    int n = 0;
    while ((pending_q.size() > 0 || expected_q.size() > 0) && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput({tag, "_drained"}, pending_q.size() + expected_q.size(), 0);
  endtask

  task automatic resetDut();
    i_rst_n          = 1'b0;
    i_request_valid  = 1'b0;
    i_response_ready = 1'b0;
    @(posedge i_clk);
    cycle++;
    expected_q.delete();
    pending_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    checkOutput("reset_response_valid", o_response_valid, 0);
    checkOutput("reset_request_ready", o_request_ready, 1);
    checkOutput("reset_read_data", o_read_data, 0);
    checkOutput("reset_error", o_error, 0);
  endtask

  function automatic req_t randomRequest();
    int          kind;
    logic [31:0] addr;
    kind = $urandom_range(0, 9);
    if (kind == 0)      addr = 32'h1000 + 4 * $urandom_range(0, 15);
    else if (kind == 1) addr = 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
    else                addr = 4 * $urandom_range(0, 15);
    return makeRequest(addr, $urandom_range(0, 1) == 1, $urandom(), 4'($urandom_range(0, 15)));
  endfunction

  initial begin
    int accept_before;
    int pop_before;
    int bubble_before;

    i_rst_n          = 1'b0;
    i_request_valid  = 1'b0;
    i_address        = '0;
    i_write          = 1'b0;
    i_write_data     = '0;
    i_strobe         = '0;
    i_response_ready = 1'b0;
    @(negedge i_clk);
    resetDut();

    // Give every word the random traffic can read a known value, plus the last word.
    for (int w = 0; w < 16; w++) pending_q.push_back(makeRequest(4 * w, 1'b1, $urandom(), 4'hF));
    pending_q.push_back(makeRequest(32'h0000_0FFC, 1'b1, 32'hC0FF_EE01, 4'hF));
    runUntilIdle("preload", 200);

    pending_q.push_back(makeRequest(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF));
    pending_q.push_back(makeRequest(32'h10, 1'b0, '0, '0));
    runUntilIdle("write_read", 50);

    pending_q.push_back(makeRequest(32'h20, 1'b1, 32'h1122_3344, 4'hF));
    pending_q.push_back(makeRequest(32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101));
    pending_q.push_back(makeRequest(32'h20, 1'b0, '0, '0));
    runUntilIdle("strobe_merge", 50);

    pending_q.push_back(makeRequest(32'h1002, 1'b0, '0, '0));
    pending_q.push_back(makeRequest(32'h1000, 1'b0, '0, '0));
    pending_q.push_back(makeRequest(32'h1000, 1'b1, 32'hFFFF_FFFF, 4'hF));
    pending_q.push_back(makeRequest(32'h12, 1'b1, 32'hFFFF_FFFF, 4'hF));
    pending_q.push_back(makeRequest(32'hFFFF_FFFC, 1'b0, '0, '0));
    pending_q.push_back(makeRequest(32'h0FFC, 1'b0, '0, '0));
    pending_q.push_back(makeRequest(32'h10, 1'b0, '0, '0));
    pending_q.push_back(makeRequest(32'h0, 1'b0, '0, '0));
    runUntilIdle("errors", 80);

    response_ready_drive = 1'b0;
    accept_before = accept_total;
    for (int i = 0; i < 6; i++) pending_q.push_back(makeRequest(4 * i, 1'b0, '0, '0));
    repeat (8) stepCycle();
    checkOutput("held_accepts", accept_total - accept_before, 4);
    checkOutput("held_ready", o_request_ready, 0);
    response_ready_drive = 1'b1;
    runUntilIdle("held_release", 80);
    checkOutput("held_total_accepts", accept_total - accept_before, 6);

    bubble_before = bubble_count;
    for (int i = 0; i < 24; i++) pending_q.push_back(makeRequest(4 * (i % 16), i % 5 == 0, $urandom(), 4'hF));
    repeat (6) stepCycle();
    pop_before = pop_total;
    repeat (12) stepCycle();
    checkOutput("steady_pops", pop_total - pop_before, 12);
    runUntilIdle("steady", 80);
    checkOutput("steady_bubbles", bubble_count - bubble_before, 0);

    response_ready_drive = 1'b0;
    for (int i = 0; i < 3; i++) pending_q.push_back(makeRequest(4 * i + 4, 1'b0, '0, '0));
    repeat (5) stepCycle();
    checkOutput("mid_reset_outstanding", expected_q.size(), 3);
    resetDut();
    response_ready_drive = 1'b1;
    pending_q.push_back(makeRequest(32'h10, 1'b0, '0, '0));
    pending_q.push_back(makeRequest(32'h20, 1'b0, '0, '0));
    runUntilIdle("after_reset", 50);

    random_ready = 1'b1;
    for (int i = 0; i < 300; i++) pending_q.push_back(randomRequest());
    runUntilIdle("random", 5000);
    random_ready = 1'b0;
    response_ready_drive = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
